// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer widths and pixel/address types.
package fb_pkg;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 24;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
endpackage

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single-port frame-buffer arbiter between scan-out reader and drawing writer.
// Optional writer anti-starvation forcing enabled by defining FB_ARB_STARVE_EN.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blank,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic              w_starve;
  logic              w_wr_pri;
  logic              r_v1;
  logic              r_valid;
  logic [DATA_W-1:0] r_hold;
  assign w_wr_pri = blank | w_starve;
  assign rd_gnt   = rst_n & rd_req & (~wr_req | ~w_wr_pri);
  assign wr_gnt   = rst_n & wr_req & (~rd_req | w_wr_pri);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= rd_gnt | wr_gnt;
      mem_we <= wr_gnt;
      if (rd_gnt | wr_gnt) begin
        mem_addr  <= wr_gnt ? wr_addr : rd_addr;
        mem_wdata <= wr_gnt ? wr_data : '0;
      end
    end
  end
  // RAM data arrives in the same cycle the second valid stage is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_v1    <= rd_gnt;
      r_valid <= r_v1;
      if (r_valid) r_hold <= mem_rdata;
    end
  end
  assign rd_valid = r_valid;
  assign rd_data  = r_valid ? mem_rdata : r_hold;
`ifdef FB_ARB_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve <= '0;
    else if (!wr_req || wr_gnt) r_starve <= '0;
    else if (r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + SW'(1);
  end
  assign w_starve = (r_starve == SW'(STARVE_MAX));
`else
  assign w_starve = 1'b0;
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed table and sequence checks for fb_port_arbiter.
module tb_fb_port_arbiter;
  import fb_pkg::*;
  logic              clk = 1'b0;
  logic              rst_n;
  logic              blank;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ram [0:1023];
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic              blank;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              exp_rg;
    logic              exp_wg;
  } vec_t;
  vec_t vt [8];
  always #5 clk = ~clk;
  fb_port_arbiter #(.STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  // Synchronous single-port RAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:0]];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wg_cnt;
    int exp_wg;
    for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(i * 3);
    mem_rdata = '0;
    rst_n = 1'b0; blank = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    vt[0] = '{1'b0, 1'b1, 1'b1, 17'd5,  17'd9,  24'h111111, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 17'd5,  17'd9,  24'h222222, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 17'd6,  17'd10, 24'h333333, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 17'd7,  17'd11, 24'h444444, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 17'd8,  17'd12, 24'h555555, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 17'd1,  17'd13, 24'h666666, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 17'd2,  17'd14, 24'h777777, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 17'd3,  17'd15, 24'h888888, 1'b0, 1'b0};
    repeat (3) cyc();
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    chk("rst_wr_gnt", 32'(wr_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    wr_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd_gnt", 32'(rd_gnt), 1);
    cyc();
    rd_req = 1'b0;
    repeat (3) cyc();
    // Burst of reads 0..7, data preloaded as addr*3
    for (int c = 0; c < 12; c++) begin
      cyc();
      rd_req = (c < 8);
      rd_addr = ADDR_W'(c);
      #1;
      chk("burst_rd_gnt", 32'(rd_gnt), 32'(c < 8));
      chk("burst_rd_valid", 32'(rd_valid), 32'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) chk("burst_rd_data", 32'(rd_data), 32'((c - 2) * 3));
    end
    chk("hold_rd_data", 32'(rd_data), 21);
    // Table-driven priority vectors, with the issue register checked after each edge
    for (int i = 0; i < 8; i++) begin
      cyc();
      blank = vt[i].blank; rd_req = vt[i].rd; wr_req = vt[i].wr;
      rd_addr = vt[i].ra; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      #1;
      chk("vec_rd_gnt", 32'(rd_gnt), 32'(vt[i].exp_rg));
      chk("vec_wr_gnt", 32'(wr_gnt), 32'(vt[i].exp_wg));
      @(posedge clk);
      #1;
      chk("vec_mem_en", 32'(mem_en), 32'(vt[i].exp_rg | vt[i].exp_wg));
      chk("vec_mem_we", 32'(mem_we), 32'(vt[i].exp_wg));
      if (vt[i].exp_wg) begin
        chk("vec_mem_addr_w", 32'(mem_addr), 32'(vt[i].wa));
        chk("vec_mem_wdata_w", 32'(mem_wdata), 32'(vt[i].wd));
      end else if (vt[i].exp_rg) begin
        chk("vec_mem_addr_r", 32'(mem_addr), 32'(vt[i].ra));
        chk("vec_mem_wdata_r", 32'(mem_wdata), 0);
      end
      rd_req = 1'b0; wr_req = 1'b0;
    end
    // Write 0xFF8000 to 100, then read it back the next cycle
    cyc();
    blank = 1'b0; rd_req = 1'b0; wr_req = 1'b1;
    wr_addr = 17'd100; wr_data = 24'hFF8000;
    #1;
    chk("wr_gnt_100", 32'(wr_gnt), 1);
    cyc();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 17'd100;
    #1;
    chk("rd_gnt_100", 32'(rd_gnt), 1);
    chk("wr_issue_we", 32'(mem_we), 1);
    chk("wr_issue_addr", 32'(mem_addr), 100);
    chk("wr_issue_data", 32'(mem_wdata), 32'h00FF8000);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("rd_issue_we", 32'(mem_we), 0);
    chk("rd_issue_en", 32'(mem_en), 1);
    chk("rd_issue_wdata", 32'(mem_wdata), 0);
    chk("rd_100_valid_early", 32'(rd_valid), 0);
    cyc();
    chk("rd_100_valid", 32'(rd_valid), 1);
    chk("rd_100_data", 32'(rd_data), 32'h00FF8000);
    cyc();
    chk("rd_100_valid_end", 32'(rd_valid), 0);
    chk("rd_100_hold", 32'(rd_data), 32'h00FF8000);
    chk("idle_mem_en", 32'(mem_en), 0);
    chk("idle_mem_addr", 32'(mem_addr), 100);
    // Continuous conflict with blank low
    wg_cnt = 0;
    for (int c = 0; c < 27; c++) begin
      cyc();
      blank = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = 17'd1; wr_addr = 17'd2;
      #1;
      if (wr_gnt) wg_cnt++;
      chk("starve_one_hot", 32'(rd_gnt ^ wr_gnt), 1);
`ifdef FB_ARB_STARVE_EN
      chk("starve_wr_gnt", 32'(wr_gnt), 32'((c % 9) == 8));
`endif
    end
`ifdef FB_ARB_STARVE_EN
    exp_wg = 3;
`else
    exp_wg = 0;
`endif
    chk("starve_count", 32'(wg_cnt), 32'(exp_wg));
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) cyc();
    // Reset one cycle after a read grant drops the in-flight read
    rd_req = 1'b1; rd_addr = 17'd4;
    #1;
    chk("drop_rd_gnt", 32'(rd_gnt), 1);
    cyc();
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("drop_mem_en", 32'(mem_en), 0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 1) rst_n = 1'b1;
      chk("drop_rd_valid", 32'(rd_valid), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates the single-port 24-bit RGB888 frame-buffer RAM between the display scan-out reader and the drawing writer. Sits between the pixel pipeline (read side), the image generator (write side) and the synchronous frame memory. It issues one memory access per cycle and returns read data with a fixed latency. Scan-out is protected against underflow, and the writer is given the port during blanking.

## Interface
- ADDR_W, 17, frame-buffer word address width (320x240 = 76800 pixels)
- DATA_W, 24, pixel width (RGB888: [23:16] R, [15:8] G, [7:0] B)
- STARVE_MAX, 8, consecutive writer denials tolerated before a forced write grant (used only with the Configuration macro)

Ports:
- clk  in  1  system clock; one clock domain only
- rst_n  in  1  asynchronous, active-low reset
- blank  in  1  high during video blanking; gives the writer priority
- rd_req  in  1  scan-out read request; held until rd_gnt
- rd_addr  in  ADDR_W  read address; stable while rd_req is high
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_data  out  DATA_W  read pixel
- rd_valid  out  1  rd_data valid; one-cycle pulse per granted read
- wr_req  in  1  writer request; held until wr_gnt
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_gnt  out  1  write accepted this cycle (combinational)
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after mem_en with mem_we=0

## Operation
- Per cycle, at most one of rd_gnt / wr_gnt is high. A grant is given only when the matching req is high.
- Priority:
  - blank=0: reader wins a conflict.
  - blank=1: writer wins a conflict.
  - A lone request always wins.
- Handshake: a request is consumed on the cycle its gnt is high. A requester that holds req high into the next cycle is making a new request.
- Grant cycle N:
  - at the edge ending N, mem_en=1, mem_we=wr_gnt, mem_addr=the granted address, mem_wdata=wr_data (write) or 0 (read).
  - Cycle with no grant: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their values.
- Read return: a two-stage valid shift register carries rd_gnt. In cycle N+2, rd_valid=1 and rd_data=mem_rdata, registered.
- rd_data holds its last value when rd_valid=0.
- Reset value of every output is 0. The comb grants are 0 while rst_n=0.
- Reset asserted mid-operation: the valid pipeline is cleared and in-flight reads are dropped (no rd_valid). Accesses already issued to the RAM are not retracted.
- blank toggling is sampled combinationally; no grant is held across cycles.

## Timing
- Read latency: rd_gnt at cycle N gives rd_valid at N+2. Throughput is one access per cycle.
- Write: rd_gnt/wr_gnt at N gives the RAM write at the edge ending N+1. A read granted at N+1 to the same address returns the new data.
- Back-to-back reads every cycle give rd_valid high continuously, 2 cycles delayed.
- No bypass or forwarding inside the block. Ordering is the RAM's issue order.

## Configuration
- FB_ARB_STARVE_EN defined:
  - A counter (width clog2(STARVE_MAX+1)) increments each cycle that wr_req=1 and wr_gnt=0.
  - When the count equals STARVE_MAX, the next conflict grants the writer even with blank=0.
  - The counter clears on wr_gnt or wr_req=0. Its reset value is 0.
- Undefined: strict priority as above. The writer may starve indefinitely while blank=0.

## Structure
- Shared package fb_pkg:
  - ADDR_W and DATA_W constants
  - typedef rgb888_t (packed r, g, b bytes)
  - typedef fb_addr_t
- The arbiter, issue register and valid pipeline are one flat module. No sub-module is needed.
- The starvation counter is a guarded always block, not a separate module.

## Test plan
- Reset: hold rst_n=0 with rd_req=wr_req=1 → all outputs 0. After release, first cycle rd_gnt=1 (blank=0).
- Reads to addresses 0..7 every cycle, RAM model preloaded with data=addr*3 → rd_valid high for 8 consecutive cycles starting 2 cycles after the first rd_gnt; rd_data=0,3,...,21.
- Conflict with blank=0 → rd_gnt=1, wr_gnt=0. Same conflict with blank=1 → wr_gnt=1, mem_we=1 next cycle, mem_addr=wr_addr.
- Write 0xFF8000 to address 100, then read address 100 the next cycle → rd_data=0xFF8000 two cycles after that rd_gnt.
- With FB_ARB_STARVE_EN, STARVE_MAX=8, continuous rd_req and wr_req, blank=0 → wr_gnt exactly once every 9 cycles. Without the macro → wr_gnt never asserts.
- Assert rst_n=0 one cycle after a rd_gnt → no rd_valid pulse follows.
